vga_frame_fetch: RTL
====================

// Module: vga_frame_fetch
// PURPOSE
// Parametrised, pipelined frame-buffer pixel fetcher between the VGA timing counters and the RGB output.
// Holds the frame in an internal simple-dual-port RAM of WORD_W-bit words.
// Fetches PPW = WORD_W/BPP packed pixels per word and expands each BPP-bit value to 24-bit grey.
// Pixel addressing uses a running pixel counter (no multiplier); a handshaked write port loads the frame.
// PARAMETERS
// H_ACTIVE  800  visible pixels per line
// V_ACTIVE  480  visible lines per frame
// BPP       1    bits per pixel; legal values 1, 2, 4, 8
// WORD_W    16   RAM word width; multiple of BPP and a power of 2
// WR_BLANK  0    1: writes are accepted only outside the active area; 0: writes accepted any cycle
// Derived: PPW=WORD_W/BPP; DEPTH=H_ACTIVE*V_ACTIVE/PPW; ADDR_W=$clog2(DEPTH). Defaults give DEPTH=24000, ADDR_W=15.
// PORTS
// clk        in   1       system clock; equals the pixel clock
// rst_n      in   1       asynchronous active-low reset
// vga_h      in   11      horizontal pixel count being displayed
// vga_v      in   11      vertical line count being displayed
// wr_valid   in   1       write request
// wr_ready   out  1       write can be accepted this cycle
// wr_addr    in   ADDR_W  RAM word address to write
// wr_data    in   WORD_W  word to write; pixel slot 0 occupies the LSBs
// wr_err     out  1       1-cycle pulse: accepted write had wr_addr >= DEPTH and was dropped
// de_out     out  1       pixel_out is valid (aligned with pixel_out)
// pixel_out  out  24      RGB {R,G,B}, 8 bits each; all three channels are equal
// frame_done out  1       1-cycle pulse, aligned with the last pixel of a frame
// BEHAVIOUR
// - Active-area flag: de = (vga_h < H_ACTIVE) && (vga_v < V_ACTIVE).
//   Counters advance by 1 per clk across the active area.
// - Pixel index: idx = (vga_h==0 && vga_v==0) ? 0 : pix_cnt.
//   pix_cnt <= idx+1 when de; pix_cnt holds when !de.
// - Word address and slot: word = idx >> log2(PPW); slot = idx & (PPW-1).
//   Pixel bits are ram_word[slot*BPP +: BPP].
// - Grey expansion: replicate the BPP-bit value to fill 8 bits.
//   BPP=1: 0->00, 1->FF. BPP=2: 2->AA. BPP=4: 5->55.
// - Pipeline, latency 3 clk from vga_h/vga_v to pixel_out:
//   S1 registers word, slot and de. S2 performs the synchronous RAM read. S3 selects, expands and registers the output.
// - When the delayed de is 0, or sync is WAIT_SYNC: pixel_out=0 and de_out=0.
// - frame_done = registered flag (idx == H_ACTIVE*V_ACTIVE-1 && de), delayed to align with S3.
// - Sync FSM:
//   WAIT_SYNC -> RUN when de && vga_h==0 && vga_v==0.
//   RUN stays RUN. Reset returns to WAIT_SYNC.
//   While in WAIT_SYNC, outputs are blanked; no pixel fetched before the first frame origin is shown.
// - Write port: wr_ready = rst_n && (!WR_BLANK || !de).
//   A write is accepted when wr_valid && wr_ready and takes effect on that clk edge.
//   wr_addr >= DEPTH: the write is accepted (ready honoured), RAM is unchanged, and wr_err pulses the next cycle.
// - Read-during-write to the same address: the read returns OLD data (read-first).
// - Reset (asynchronous assert, synchronous release): pixel_out=0, de_out=0, frame_done=0, wr_err=0.
//   Reset also sets pix_cnt=0, clears pipeline valid flags and sets sync=WAIT_SYNC.
//   RAM contents are NOT cleared.
// - Reset mid-frame: output stays blank until the next (0,0) origin, then output is correct.
// - pix_cnt wraps only via the origin reload, never by overflow; pix_cnt width = $clog2(H_ACTIVE*V_ACTIVE)+1.
// TESTING
// 1. Defaults: write word0=16'h0001. Drive (h,v)=(0,0),(1,0),(2,0) on consecutive clks.
//    3 clk later: pixel_out = FFFFFF, 000000, 000000; de_out=1 for all three.
// 2. Write word50=16'h8000. Frame runs to (15,1), index 815.
//    -> pixel_out=FFFFFF for that pixel only; (0,1), index 800, gives 000000.
// 3. BPP=4, write word0=16'hA5F0. Pixels 0..3 -> 000000, FFFFFF, 555555, AAAAAA.
// 4. WR_BLANK=1: wr_valid held during the active line -> wr_ready=0, RAM unchanged.
//    At h=H_ACTIVE -> accepted; wr_addr=24000 -> wr_err pulses once, no RAM change.
// 5. Assert rst_n=0 at (400,200), release at (10,201) -> de_out=0 for the rest of the frame.
//    At the next (0,0) correct pixels resume after 3 clk; frame_done pulses at (799,479)+3.
// 6. Same-cycle write/read of word0 (old 0000, new FFFF) at (0,0) -> pixel 0 shows 000000.
//    The next frame shows FFFFFF.

Source files
------------

// File: rtl/vga_frame_fetch.sv
// vga_frame_fetch: pipelined frame-buffer pixel fetcher for VGA output.
// Packed BPP-bit pixels in an internal RAM, expanded to 24-bit grey.
module vga_frame_fetch #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int BPP      = 1,
  parameter int WORD_W   = 16,
  parameter bit WR_BLANK = 1'b0,
  localparam int PPW     = WORD_W / BPP,
  localparam int DEPTH   = H_ACTIVE * V_ACTIVE / PPW,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       vga_h,
  input  logic [10:0]       vga_v,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_err,
  output logic              de_out,
  output logic [23:0]       pixel_out,
  output logic              frame_done
);

  localparam int TOTAL  = H_ACTIVE * V_ACTIVE;
  localparam int PC_W   = $clog2(TOTAL) + 1;
  localparam int SH     = $clog2(PPW);
  localparam int SLOT_W = (SH > 0) ? SH : 1;

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  typedef enum logic {
    WAIT_SYNC,
    RUN
  } sync_t;

  sync_t sync;

  logic              de;
  logic              origin;
  logic              take;
  logic              last;
  logic [PC_W-1:0]   pix_cnt;
  logic [PC_W-1:0]   idx;
  logic [ADDR_W-1:0] word;
  logic [SLOT_W-1:0] slot;

  logic              wr_take;
  logic              wr_bad;

  logic [ADDR_W-1:0] s1_word;
  logic [SLOT_W-1:0] s1_slot;
  logic              s1_vld;
  logic              s1_last;

  logic [WORD_W-1:0] rd_word;
  logic [SLOT_W-1:0] s2_slot;
  logic              s2_vld;
  logic              s2_last;

  logic [BPP-1:0]    pix_bits;
  logic [7:0]        grey;

  logic [WORD_W-1:0] mem [DEPTH];

  assign de     = (vga_h < H_LIM) && (vga_v < V_LIM);
  assign origin = (vga_h == '0) && (vga_v == '0);
  assign idx    = origin ? '0 : pix_cnt;
  // The origin pixel itself is shown even while still waiting for sync.
  assign take   = de && ((sync == RUN) || origin);
  assign last   = de && (idx == PC_W'(TOTAL - 1));
  assign word   = ADDR_W'(idx >> SH);
  assign slot   = SLOT_W'(idx & PC_W'(PPW - 1));

  assign wr_ready = rst_n && (!WR_BLANK || !de);
  assign wr_take  = wr_valid && wr_ready;
  // Widened compare so DEPTH == 2**ADDR_W does not wrap to zero.
  assign wr_bad   = {1'b0, wr_addr} >= (ADDR_W + 1)'(DEPTH);

  // Running pixel index; reloaded at the frame origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
    end else if (de) begin
      pix_cnt <= idx + 1'b1;
    end
  end

  // Sync FSM: blank output until the first frame origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= WAIT_SYNC;
    end else begin
      unique case (sync)
        WAIT_SYNC: if (de && origin) sync <= RUN;
        RUN:       sync <= RUN;
      endcase
    end
  end

  // S1: register word address, slot and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_word <= '0;
      s1_slot <= '0;
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      s1_word <= word;
      s1_slot <= slot;
      s1_vld  <= take;
      s1_last <= last && take;
    end
  end

  // Frame RAM: read-first, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    rd_word <= mem[s1_word];
    if (wr_take && !wr_bad) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // S2: carry slot and valid alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_slot <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
    end else begin
      s2_slot <= s1_slot;
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
    end
  end

  // Select the pixel and replicate it to 8 grey bits.
  always_comb begin
    pix_bits = BPP'(rd_word >> (32'(s2_slot) * BPP));
    grey     = {(8 / BPP){pix_bits}};
  end

  // S3: registered RGB output, blanked when invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out  <= '0;
      de_out     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pixel_out  <= s2_vld ? {grey, grey, grey} : 24'h0;
      de_out     <= s2_vld;
      frame_done <= s2_last;
    end
  end

  // One-cycle error pulse for dropped writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_take && wr_bad;
    end
  end

endmodule
